// File: rtl/seqpu_mem_pkg.sv
// Shared definitions for the seqpu SRAM arbiter: FSM state encoding, port
// index constants and bus widths. Imported by mem_arbiter and rr_arbiter2.
package seqpu_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Index of the port that is not p; used for round-robin hand-over.
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port request arbiter.
// Ports:
//   req_i        [1:0] request vector, bit 0 = CPU port, bit 1 = AUX port
//   last_grant_i       index of the port served most recently
//   grant_o            index of the winning port (valid only with valid_o)
//   valid_o            at least one port is requesting
// With CPU_PRIORITY=1 the CPU port wins every tie, otherwise the port that
// was not served last wins.
module rr_arbiter2
  import seqpu_mem_pkg::*;
#(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  // Winner selection from the current request pattern.
  always_comb begin
    grant_o = PORT_CPU;
    valid_o = |req_i;
    case (req_i)
      2'b01: grant_o = PORT_CPU;
      2'b10: grant_o = PORT_AUX;
      2'b11: begin
        if (CPU_PRIORITY) begin
          grant_o = PORT_CPU;
        end else begin
          grant_o = other_port(last_grant_i);
        end
      end
      default: grant_o = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one asynchronous SRAM port between the seqpu CPU (port 0) and a
// second bus master (port 1). Each access is IDLE -> ACCESS (strobe low for
// ACCESS_CYCLES cycles) -> DONE (strobes high, address/data held, one-cycle
// ack) -> IDLE. All memory-side outputs, acks and read data are registered.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pN_req/we/addr/wdata          request from port N (held until pN_ack)
//   pN_ack, pN_rdata              completion pulse and read data for port N
//   mem_address, mem_data_out     SRAM address and write data
//   mem_data_in                   SRAM read data
//   mem_wren_n, mem_oen_n         SRAM write strobe / output enable, active low
//   busy                          high outside IDLE
//   grant                         current or most recent owner
module mem_arbiter
  import seqpu_mem_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter bit          CPU_PRIORITY  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wren_n,
  output logic              mem_oen_n,
  output logic              busy,
  output logic              grant
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wren_n_q, wren_n_d;
  logic              oen_n_q, oen_n_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              arb_grant_s;
  logic              arb_valid_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_arbiter2 #(
    .CPU_PRIORITY (CPU_PRIORITY)
  ) u_arb (
    .req_i        ({p1_req, p0_req}),
    .last_grant_i (last_q),
    .grant_o      (arb_grant_s),
    .valid_o      (arb_valid_s)
  );

  assign sel_we_s    = (arb_grant_s == PORT_AUX) ? p1_we    : p0_we;
  assign sel_addr_s  = (arb_grant_s == PORT_AUX) ? p1_addr  : p0_addr;
  assign sel_wdata_s = (arb_grant_s == PORT_AUX) ? p1_wdata : p0_wdata;

  // Next-state and output decode of the access sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    wren_n_d = wren_n_q;
    oen_n_d  = oen_n_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          grant_d  = arb_grant_s;
          we_d     = sel_we_s;
          addr_d   = sel_addr_s;
          dout_d   = sel_wdata_s;
          cnt_d    = CNT_LOAD;
          // Exactly one strobe goes low, selected by the latched operation.
          wren_n_d = ~sel_we_s;
          oen_n_d  = sel_we_s;
          state_d  = ACCESS;
        end else begin
          wren_n_d = 1'b1;
          oen_n_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ACCESS;
        end else begin
          // Read data is sampled while oen_n is still low on this edge.
          if (!we_q) begin
            if (grant_q == PORT_AUX) begin
              rdata1_d = mem_data_in;
            end else begin
              rdata0_d = mem_data_in;
            end
          end else begin
            rdata0_d = rdata0_q;
          end
          // Ack is registered on the same edge so it is high during DONE.
          if (grant_q == PORT_AUX) begin
            ack1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
          end
          wren_n_d = 1'b1;
          oen_n_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        wren_n_d = 1'b1;
        oen_n_d  = 1'b1;
        last_d   = grant_q;
        state_d  = IDLE;
      end
      default: begin
        wren_n_d = 1'b1;
        oen_n_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // State and bus registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      grant_q  <= PORT_CPU;
      last_q   <= PORT_AUX;
      addr_q   <= '0;
      dout_q   <= '0;
      wren_n_q <= 1'b1;
      oen_n_q  <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      wren_n_q <= wren_n_d;
      oen_n_q  <= oen_n_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign p0_ack       = ack0_q;
  assign p1_ack       = ack1_q;
  assign p0_rdata     = rdata0_q;
  assign p1_rdata     = rdata1_q;
  assign mem_address  = addr_q;
  assign mem_data_out = dout_q;
  assign mem_wren_n   = wren_n_q;
  assign mem_oen_n    = oen_n_q;
  assign busy         = (state_q != IDLE);
  assign grant        = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Three instances with different timing/priority
// settings run side by side, each with its own requesters, SRAM stand-in
// and a transaction-level reference model that predicts every output each
// cycle from the start cycle of the current access.
module tb_mem_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : u
    localparam int AC  = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    localparam bit PRI = (g == 2);

    logic             rst;
    logic [1:0]       req, we, ack;
    logic [1:0][15:0] addr, wdata, rdata;
    logic [15:0]      mem_address, mem_data_out, mem_data_in;
    logic             mem_wren_n, mem_oen_n, busy, grant;

    // SRAM stand-in: read data is a fixed function of the address, so that
    // address 16'h0010 returns 16'hBEEF.
    assign mem_data_in = mem_address ^ 16'hBEFF;

    mem_arbiter #(.ACCESS_CYCLES(AC), .CPU_PRIORITY(PRI)) dut (
      .clk          (clk),
      .rst          (rst),
      .p0_req       (req[0]),
      .p0_we        (we[0]),
      .p0_addr      (addr[0]),
      .p0_wdata     (wdata[0]),
      .p0_ack       (ack[0]),
      .p0_rdata     (rdata[0]),
      .p1_req       (req[1]),
      .p1_we        (we[1]),
      .p1_addr      (addr[1]),
      .p1_wdata     (wdata[1]),
      .p1_ack       (ack[1]),
      .p1_rdata     (rdata[1]),
      .mem_address  (mem_address),
      .mem_data_out (mem_data_out),
      .mem_data_in  (mem_data_in),
      .mem_wren_n   (mem_wren_n),
      .mem_oen_n    (mem_oen_n),
      .busy         (busy),
      .grant        (grant)
    );

    task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
      req[p]   = 1'b1;
      we[p]    = w;
      addr[p]  = a;
      wdata[p] = d;
    endtask

    // One requester cycle. mode 0: random traffic, 1: both ports keep
    // issuing reads back to back, 2: finish outstanding requests only.
    task automatic step(input int mode);
      @(posedge clk);
      #2;
      for (int p = 0; p < 2; p++) begin
        if (req[p] && ack[p]) begin
          if (mode == 1) begin
            issue(p, 1'b0, 16'($urandom_range(0, 255)), 16'($urandom));
          end else if (mode == 0 && $urandom_range(0, 1) == 1) begin
            issue(p, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
          end else begin
            req[p] = 1'b0;
          end
        end else if (!req[p] && mode == 1) begin
          issue(p, 1'b0, 16'($urandom_range(0, 255)), 16'($urandom));
        end else if (!req[p] && mode == 0 && $urandom_range(0, 2) == 0) begin
          issue(p, 1'($urandom), 16'($urandom), 16'($urandom));
        end
      end
    endtask

    // Stimulus sequence for this instance.
    initial begin
      rst   = 1'b1;
      req   = 2'b00;
      we    = 2'b00;
      addr  = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (3) step(2);
      // Directed transactions: port 0 read of 16'h0010, port 1 write.
      issue(0, 1'b0, 16'h0010, 16'h0000);
      repeat (8) step(2);
      issue(1, 1'b1, 16'h1234, 16'hA5A5);
      repeat (8) step(2);
      repeat (300) step(0);
      repeat (40) step(1);
      repeat (12) step(2);
      // Reset raised in the second cycle after a write is granted.
      issue(0, 1'b1, 16'h0042, 16'h1357);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      check_eq($sformatf("u%0d_abort_wren_n", g), 32'(mem_wren_n), 32'd1);
      check_eq($sformatf("u%0d_abort_busy", g), 32'(busy), 32'd0);
      check_eq($sformatf("u%0d_abort_ack", g), 32'(ack), 32'd0);
      // The still-pending request is re-issued and must complete.
      repeat (12) step(2);
    end

    // Reference model: an access granted in IDLE cycle s has its strobe low
    // in cycles s+1..s+AC, its ack in s+AC+1, and the next grant can happen
    // in cycle s+AC+2. Outputs are compared every cycle at the falling edge.
    initial begin
      bit          valid = 1'b0;
      bit          act = 1'b0;
      bit          in_txn;
      int          cyc = 0;
      int          s = 0;
      int          k;
      logic        w = 1'b0;
      logic        tw = 1'b0;
      logic        last_g = 1'b1;
      logic        e_grant = 1'b0;
      logic [15:0] ta = '0;
      logic [15:0] td = '0;
      logic [15:0] e_addr = '0;
      logic [15:0] e_dout = '0;
      logic [15:0] e_rd0 = '0;
      logic [15:0] e_rd1 = '0;
      forever begin
        @(negedge clk);
        if (valid) begin
          k = act ? (cyc - s) : 0;
          in_txn = act && (k >= 1) && (k <= AC + 1);
          if (in_txn && k == AC + 1) begin
            if (!tw && w == 1'b0) e_rd0 = ta ^ 16'hBEFF;
            if (!tw && w == 1'b1) e_rd1 = ta ^ 16'hBEFF;
            last_g = w;
          end
          check_eq($sformatf("u%0d_c%0d_oen_n", g, cyc), 32'(mem_oen_n),
                   32'(!(in_txn && k <= AC && !tw)));
          check_eq($sformatf("u%0d_c%0d_wren_n", g, cyc), 32'(mem_wren_n),
                   32'(!(in_txn && k <= AC && tw)));
          check_eq($sformatf("u%0d_c%0d_ack", g, cyc), 32'(ack),
                   {30'd0, in_txn && k == AC + 1 && w, in_txn && k == AC + 1 && !w});
          check_eq($sformatf("u%0d_c%0d_busy", g, cyc), 32'(busy), 32'(in_txn));
          check_eq($sformatf("u%0d_c%0d_addr", g, cyc), 32'(mem_address), 32'(e_addr));
          check_eq($sformatf("u%0d_c%0d_dout", g, cyc), 32'(mem_data_out), 32'(e_dout));
          check_eq($sformatf("u%0d_c%0d_grant", g, cyc), 32'(grant), 32'(e_grant));
          check_eq($sformatf("u%0d_c%0d_rdata0", g, cyc), 32'(rdata[0]), 32'(e_rd0));
          check_eq($sformatf("u%0d_c%0d_rdata1", g, cyc), 32'(rdata[1]), 32'(e_rd1));
          check_eq($sformatf("u%0d_c%0d_strobe_mutex", g, cyc), 32'(mem_wren_n | mem_oen_n), 32'd1);
          check_eq($sformatf("u%0d_c%0d_ack_onehot", g, cyc), 32'(ack[0] & ack[1]), 32'd0);
          if (!in_txn) act = 1'b0;
          if (!rst && !in_txn && (req != 2'b00)) begin
            if (req == 2'b01)      w = 1'b0;
            else if (req == 2'b10) w = 1'b1;
            else if (PRI)          w = 1'b0;
            else                   w = ~last_g;
            act     = 1'b1;
            s       = cyc;
            tw      = we[w];
            ta      = addr[w];
            td      = wdata[w];
            e_addr  = ta;
            e_dout  = td;
            e_grant = w;
          end
        end
        if (rst) begin
          valid   = 1'b1;
          act     = 1'b0;
          e_addr  = '0;
          e_dout  = '0;
          e_grant = 1'b0;
          e_rd0   = '0;
          e_rd1   = '0;
          last_g  = 1'b1;
        end
        cyc++;
      end
    end
  end

  // Run length covers every instance's stimulus sequence with margin.
  initial begin
    repeat (450) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single asynchronous SRAM port (address, data_out, data_in, wren_n, oen_n) between the seqpu cpu core (port 0) and a second bus master (port 1, e.g. boot loader or DMA).
- Sequences each SRAM access with registered, glitch-free strobes.
- Arbitrates simultaneous requests round-robin, or with fixed CPU priority.
- Returns read data and a one-cycle ack to the winner.

Parameters:
- ACCESS_CYCLES, 1, number of cycles a strobe (oen_n or wren_n) is held low per access; legal range 1..15.
- CPU_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 request; held until p0_ack
- p0_we  input  1  port 0 write (1) / read (0); stable while p0_req is high
- p0_addr  input  16  port 0 address; stable while p0_req is high
- p0_wdata  input  16  port 0 write data; stable while p0_req is high
- p0_ack  output  1  one-cycle completion pulse for port 0
- p0_rdata  output  16  port 0 read data; valid while p0_ack is high
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
- mem_address  output  16  SRAM address
- mem_data_out  output  16  SRAM write data
- mem_data_in  input  16  SRAM read data
- mem_wren_n  output  1  SRAM write strobe, active low
- mem_oen_n  output  1  SRAM output enable, active low
- busy  output  1  high in any state other than IDLE
- grant  output  1  index of the current or most recent owner

Behaviour:
- Reset values (one edge after rst is high): state IDLE, mem_wren_n=1, mem_oen_n=1, mem_address=0, mem_data_out=0, both ack=0, both rdata=0, grant=0, last-grant register=1 (so port 0 wins the first tie), counter=0.
- All memory-side outputs are registered. mem_wren_n and mem_oen_n are never low in the same cycle; this is invariant, including during reset.
- States:
  - IDLE: no strobes asserted.
    - If no request: stay in IDLE.
    - If a request is present: choose the winner, latch its addr, wdata and we into mem_address, mem_data_out and an op register, set grant, set counter=ACCESS_CYCLES-1, go to ACCESS.
    - On entry to ACCESS: mem_oen_n=0 for a read, mem_wren_n=0 for a write.
  - ACCESS: the strobe is held low.
    - If counter!=0: decrement the counter.
    - If counter==0: for a read, capture mem_data_in into the winner's rdata; deassert both strobes; go to DONE.
  - DONE: both strobes high; mem_address and mem_data_out are held (write hold time).
    - Pulse the winner's ack=1 for this cycle only.
    - Update last-grant to the winner; go to IDLE.
- Arbitration (IDLE only):
  - Only one port requesting: that port wins.
  - Both requesting, CPU_PRIORITY=1: port 0 wins.
  - Both requesting, CPU_PRIORITY=0: the port not equal to last-grant wins.
  - The losing port's req is ignored until the next IDLE.
- Latency: let cycle 0 be an IDLE cycle with req high.
  - Strobe is low in cycles 1..ACCESS_CYCLES.
  - ack is high in cycle ACCESS_CYCLES+1.
  - IDLE is re-entered in cycle ACCESS_CYCLES+2.
  - Throughput: one access per ACCESS_CYCLES+2 cycles.
- Requester handshake:
  - On the edge that ends its ack cycle, the requester must drop req or present the next transaction.
  - A req still high in the following IDLE cycle is a new transaction.
- Ack and rdata:
  - A port's rdata holds its last read value until the next read for that port.
  - Ack is never raised for a port that was not granted.
  - A write never modifies rdata.
- A req that drops mid-access (protocol violation) does not abort the access; it completes and acks normally.
- rst high in any state: next edge forces the reset values, aborting any access with no ack. A strobe never stays low past that edge.
- busy=1 in ACCESS and DONE.

Decomposition:
- Shared package seqpu_mem_pkg holds:
  - state enum: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2
  - port index constants: PORT_CPU=1'b0, PORT_AUX=1'b1
  - width constant: ADDR_W=16, DATA_W=16
- One sub-module, rr_arbiter2: takes req[1:0], last-grant and CPU_PRIORITY; outputs the grant index and a valid signal.
- Counter, FSM and bus registers live in mem_arbiter itself.

Test Plan:
- rst high for 2 cycles, then low, no requests -> strobes stay 1, mem_address=0, busy=0, no ack.
- ACCESS_CYCLES=1, p0 read addr 16'h0010, SRAM returns 16'hBEEF -> mem_oen_n=0 in cycle 1 only, p0_ack in cycle 2 with p0_rdata=16'hBEEF.
- ACCESS_CYCLES=3, p1 write addr 16'h1234 data 16'hA5A5 -> mem_wren_n=0 in cycles 1-3; address/data held through cycle 4 (DONE); p1_ack in cycle 4; p0_ack stays 0.
- CPU_PRIORITY=0, both ports request reads continuously -> grants alternate 0,1,0,1, one ack every 3 cycles; CPU_PRIORITY=1 -> port 0 served every time while it requests.
- rst raised in the second ACCESS cycle of a write (ACCESS_CYCLES=3) -> mem_wren_n=1 on the next edge, no ack, state IDLE; a re-issued request completes normally.
- Every cycle of every scenario: assert (mem_wren_n || mem_oen_n) and at most one ack high.
